// File: rtl/ofm_write_arbiter_pkg.sv
// Shared constants and types for the OFM SRAM write-port arbiter slice.
package vit_ofm_pkg;
   localparam int NUM_REQ    = 4;
   localparam int TILE_WORDS = 1024;
   localparam int TILE_CNT_W = $clog2(TILE_WORDS);
   localparam int REQ_IDX_W  = $clog2(NUM_REQ);

   typedef enum logic {IDLE, BURST} state_t;
   typedef logic [REQ_IDX_W-1:0] req_idx_t;
endpackage

// File: rtl/ofm_write_arbiter_if.sv
// Drain-engine request bus plus the shared OFM SRAM write port.
interface ofm_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 12
);
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0][ADDR_W-1:0] cfg_base;
   logic [NUM_REQ-1:0]             req_ready;
   logic                           wr_en;
   logic [ADDR_W-1:0]              wr_addr;
   logic [DATA_W-1:0]              wr_data;
   logic [NUM_REQ-1:0]             tile_done;
   logic                           busy;

   modport master (
      output req_valid, req_data, cfg_base,
      input  req_ready, wr_en, wr_addr, wr_data, tile_done, busy
   );

   modport slave (
      input  req_valid, req_data, cfg_base,
      output req_ready, wr_en, wr_addr, wr_data, tile_done, busy
   );
endinterface

// File: rtl/ofm_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after last_i, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);
   import vit_ofm_pkg::*;

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((int'(last_i) + off) % NUM_REQ);
         if (!any_o && req_i[cand]) begin
            any_o         = 1'b1;
            idx_o         = cand;
            grant_o[cand] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ofm_write_arbiter.sv
// Burst-locked round-robin arbiter sharing one OFM SRAM write port between drain engines.
module ofm_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 12,
   parameter int TILE_WORDS = vit_ofm_pkg::TILE_WORDS
) (
   input logic                i_clk,
   input logic                i_rst,
   ofm_write_arbiter_if.slave bus
);
   import vit_ofm_pkg::*;

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam int               CNT_W    = $clog2(TILE_WORDS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILE_WORDS - 1);

   state_t             state_q;
   logic [IDX_W-1:0]   gnt_idx_q;
   logic [IDX_W-1:0]   rr_last_q;
   logic [NUM_REQ-1:0] gnt_oh_q;
   logic [ADDR_W-1:0]  base_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               wr_en_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic [NUM_REQ-1:0] tile_done_q;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               accept_d;
   logic               last_d;
   logic [ADDR_W-1:0]  addr_d;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i   (bus.req_valid),
      .last_i  (rr_last_q),
      .grant_o (pick_oh),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   assign accept_d = (state_q == BURST) && bus.req_valid[gnt_idx_q];
   assign last_d   = (cnt_q == LAST_CNT);
   // Address arithmetic wraps modulo the SRAM depth by design.
   assign addr_d   = base_q + ADDR_W'(cnt_q);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         gnt_idx_q   <= '0;
         gnt_oh_q    <= '0;
         rr_last_q   <= IDX_W'(NUM_REQ - 1);
         base_q      <= '0;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         tile_done_q <= '0;
      end else begin
         wr_en_q     <= 1'b0;
         tile_done_q <= '0;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  gnt_idx_q <= pick_idx;
                  gnt_oh_q  <= pick_oh;
                  rr_last_q <= pick_idx;
                  base_q    <= bus.cfg_base[pick_idx];
                  cnt_q     <= '0;
                  state_q   <= BURST;
               end
            end
            BURST: begin
               // Grant is held through valid gaps; only the tile's last beat releases it.
               if (accept_d) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr_d;
                  wr_data_q <= bus.req_data[gnt_idx_q];
                  cnt_q     <= cnt_q + CNT_W'(1);
                  if (last_d) begin
                     tile_done_q <= gnt_oh_q;
                     state_q     <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state_q == BURST) ? gnt_oh_q : '0;
   assign bus.busy      = (state_q == BURST);
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.tile_done = tile_done_q;
endmodule
